// File: rtl/alu_4.sv
// ----------------------------------------------------------------------------
// alu_4 -- registered ALU: add/sub, bitwise logic, NOT and 1-bit logical shifts
//
// Ports
//   clk       in   1      clock, outputs update on rising edge
//   rst_n     in   1      asynchronous active-low reset (clears all outputs)
//   A         in   WIDTH  operand A
//   B         in   WIDTH  operand B
//   Sel       in   4      operation select
//   Y         out  WIDTH  registered result
//   carry     out  1      registered carry / no-borrow / shifted-out bit
//   overflow  out  1      registered two's-complement overflow
// ----------------------------------------------------------------------------
module alu_4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Sel,
    output logic [WIDTH-1:0] Y,
    output logic             carry,
    output logic             overflow
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_NAND = 4'b0101,
        OP_NOR  = 4'b0110,
        OP_XNOR = 4'b0111,
        OP_NOTA = 4'b1000,
        OP_SHL  = 4'b1001,
        OP_SHR  = 4'b1010
    } op_e;

    localparam int unsigned MSB = WIDTH - 1;

    op_e              op;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH-1:0] y_d,     y_q;
    logic             carry_d, carry_q;
    logic             ovf_d,   ovf_q;

    assign op = op_e'(Sel);

    // Subtraction as A + ~B + 1 so the top bit is the "no borrow" flag.
    assign add_sum = {1'b0, A} + {1'b0, B};
    assign sub_sum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        y_d     = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (op)
            OP_ADD: begin
                y_d     = add_sum[WIDTH-1:0];
                carry_d = add_sum[WIDTH];
                // Same-sign operands producing a different-sign result.
                ovf_d   = (A[MSB] == B[MSB]) && (add_sum[MSB] != A[MSB]);
            end
            OP_SUB: begin
                y_d     = sub_sum[WIDTH-1:0];
                carry_d = sub_sum[WIDTH];
                // Opposite-sign operands where the result loses A's sign.
                ovf_d   = (A[MSB] != B[MSB]) && (sub_sum[MSB] != A[MSB]);
            end
            OP_AND:  y_d = A & B;
            OP_OR:   y_d = A | B;
            OP_XOR:  y_d = A ^ B;
            OP_NAND: y_d = ~(A & B);
            OP_NOR:  y_d = ~(A | B);
            OP_XNOR: y_d = ~(A ^ B);
            OP_NOTA: y_d = ~A;
            OP_SHL: begin
                y_d     = {A[WIDTH-2:0], 1'b0};
                carry_d = A[MSB];
            end
            OP_SHR: begin
                y_d     = {1'b0, A[WIDTH-1:1]};
                carry_d = A[0];
            end
            default: begin
                y_d     = '0;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            y_q     <= y_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Y        = y_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_4.sv
// ----------------------------------------------------------------------------
// tb_alu_4 -- self-checking bench for alu_4 (WIDTH=4). Expected results come
// from an integer-arithmetic reference model, queued when stimulus is driven
// and popped once the registered output is available.
// ----------------------------------------------------------------------------
module tb_alu_4;

    typedef struct {
        int    y;
        int    c;
        int    v;
        string tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] A, B, Sel;
    logic [3:0] Y;
    logic       carry, overflow;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    alu_4 #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .Sel      (Sel),
        .Y        (Y),
        .carry    (carry),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int sx(input int v);
        return (v > 7) ? v - 16 : v;
    endfunction

    function automatic exp_t model(input int a, input int b, input int sel);
        exp_t e;
        int   s;
        e.y = 0; e.c = 0; e.v = 0;
        e.tag = $sformatf("sel=%0d a=%0d b=%0d", sel, a, b);
        case (sel)
            0: begin
                e.y = (a + b) % 16;
                e.c = (a + b > 15) ? 1 : 0;
                s   = sx(a) + sx(b);
                e.v = (s > 7 || s < -8) ? 1 : 0;
            end
            1: begin
                e.y = (a - b + 16) % 16;
                e.c = (a >= b) ? 1 : 0;
                s   = sx(a) - sx(b);
                e.v = (s > 7 || s < -8) ? 1 : 0;
            end
            2:  e.y = a & b;
            3:  e.y = a | b;
            4:  e.y = a ^ b;
            5:  e.y = 15 - (a & b);
            6:  e.y = 15 - (a | b);
            7:  e.y = 15 - (a ^ b);
            8:  e.y = 15 - a;
            9:  begin e.y = (a * 2) % 16; e.c = a / 8; end
            10: begin e.y = a / 2;        e.c = a % 2; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_outputs(input string tag, input int y, input int c, input int v);
        check_val({tag, " Y"}, int'(Y), y);
        check_val({tag, " carry"}, int'(carry), c);
        check_val({tag, " ovf"}, int'(overflow), v);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("scoreboard empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check_outputs(e.tag, e.y, e.c, e.v);
        end
    endtask

    // Drive at negedge, queue expectation, check 1 time unit after capture edge.
    task automatic step(input int a, input int b, input int sel);
        @(negedge clk);
        A   = 4'(a);
        B   = 4'(b);
        Sel = 4'(sel);
        sb.push_back(model(a, b, sel));
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        rst_n = 1'b0;
        A = '0; B = '0; Sel = '0;
        #1;
        check_outputs("reset initial", 0, 0, 0);
        @(negedge clk);
        A = 4'd6; B = 4'd11; Sel = 4'd0;
        @(posedge clk);
        #1;
        check_outputs("reset held over edge", 0, 0, 0);

        // Release with ADD presented: zeros until the first edge, then result.
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(model(6, 11, 0));
        #1;
        check_outputs("after release pre-edge", 0, 0, 0);
        @(posedge clk);
        #1;
        pop_check();

        // Every opcode with A=0110, B=1011, including reserved encodings.
        for (int s = 0; s < 16; s++) step(6, 11, s);

        // Shift carry-out and arithmetic boundaries.
        step(9, 11, 9);
        step(9, 11, 10);
        step(7, 1, 0);
        step(15, 1, 0);
        step(5, 5, 1);
        step(8, 1, 1);
        step(0, 1, 1);
        step(15, 15, 0);

        // Inputs changing between edges must not disturb the held result.
        step(6, 11, 0);
        #2;
        A = 4'd3; B = 4'd3; Sel = 4'd1;
        #2;
        check_outputs("hold mid-cycle", 1, 1, 0);

        // Asynchronous reset in the middle of a cycle clears immediately.
        step(6, 11, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async reset mid-run", 0, 0, 0);
        sb.delete();
        @(negedge clk);
        A = 4'd6; B = 4'd11; Sel = 4'd1;
        rst_n = 1'b1;
        sb.push_back(model(6, 11, 1));
        #1;
        check_outputs("re-release pre-edge", 0, 0, 0);
        @(posedge clk);
        #1;
        pop_check();

        // Random sweep.
        for (int i = 0; i < 60; i++)
            step($urandom_range(15), $urandom_range(15), $urandom_range(15));

        if (sb.size() != 0) check_val("scoreboard leftover", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
